// File: rtl/vuprs_adc_sample_sched.sv
// AD7606 sample scheduler: periodic conversion trigger, burst/continuous runs,
// channel capture and serialisation onto a valid/ready word stream.
module vuprs_adc_sample_sched #(
  parameter int unsigned TRIG_HIGH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned MIN_DIV        = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [23:0]  cfg_divider,
  input  logic [15:0]  cfg_burst,
  output logic         adc_trigger,
  input  logic         adc_sampling,
  input  logic         adc_error,
  input  logic         adc_reset_down,
  input  logic [127:0] adc_ch_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [15:0]  m_data,
  output logic [2:0]   m_channel,
  output logic         m_last,
  output logic         run,
  output logic         done,
  output logic [15:0]  sample_cnt,
  output logic [15:0]  overrun_cnt,
  output logic         err_timeout,
  output logic         err_adc
);

  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TRIG_HIGH + 1);
  localparam logic [23:0] MIN_DIV_V = 24'(MIN_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ARM,
    S_TRIG,
    S_WAIT_DONE,
    S_OUT,
    S_CHECK
  } state_t;

  state_t         state_q, state_d;
  logic [23:0]    div_q, div_d;
  logic [15:0]    burst_q, burst_d;
  logic [23:0]    per_q, per_d;
  logic [TCW-1:0] trig_cnt_q, trig_cnt_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [127:0]   buf_q, buf_d;
  logic           stop_pend_q, stop_pend_d;
  logic           samp_q, fall_q, err_s_q;

  logic           trig_q, trig_d;
  logic           valid_q, valid_d;
  logic [15:0]    data_q, data_d;
  logic [2:0]     chan_q, chan_d;
  logic           last_q, last_d;
  logic           run_q, run_d;
  logic           done_q, done_d;
  logic [15:0]    scnt_q, scnt_d;
  logic [15:0]    ocnt_q, ocnt_d;
  logic           etmo_q, etmo_d;
  logic           eadc_q, eadc_d;

  logic           counting;
  logic           tick;
  logic           ovf_inc;
  logic           stop_any;
  logic [2:0]     nxt_ch;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    burst_d     = burst_q;
    per_d       = '0;
    trig_cnt_d  = '0;
    to_cnt_d    = to_cnt_q;
    buf_d       = buf_q;
    stop_pend_d = stop_pend_q;
    valid_d     = valid_q;
    data_d      = data_q;
    chan_d      = chan_q;
    last_d      = last_q;
    scnt_d      = scnt_q;
    ocnt_d      = ocnt_q;
    etmo_d      = etmo_q;
    eadc_d      = eadc_q;
    ovf_inc     = 1'b0;
    nxt_ch      = chan_q + 3'd1;
    stop_any    = stop | stop_pend_q;

    // Period counter is held at zero until the controller is ready, so the
    // first trigger lands exactly one period after leaving WAIT_RDY.
    counting = (state_q != S_IDLE) && (state_q != S_WAIT_RDY);
    tick     = counting && (per_q == div_q);
    if (counting) begin
      per_d = tick ? '0 : per_q + 24'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          div_d       = (cfg_divider < MIN_DIV_V) ? MIN_DIV_V : cfg_divider;
          burst_d     = cfg_burst;
          scnt_d      = '0;
          ocnt_d      = '0;
          etmo_d      = 1'b0;
          eadc_d      = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (stop_any) begin
          state_d = S_IDLE;
        end else if (adc_reset_down) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (stop_any) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (adc_sampling) begin
            ovf_inc = 1'b1;
          end else begin
            state_d = S_TRIG;
          end
        end
      end
      S_TRIG: begin
        ovf_inc    = tick;
        trig_cnt_d = trig_cnt_q + TCW'(1);
        if (trig_cnt_q == TCW'(TRIG_HIGH - 1)) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        ovf_inc = tick;
        if (fall_q) begin
          if (err_s_q) begin
            eadc_d  = 1'b1;
            state_d = S_CHECK;
          end else begin
            buf_d   = adc_ch_data;
            valid_d = 1'b1;
            data_d  = adc_ch_data[15:0];
            chan_d  = '0;
            last_d  = 1'b0;
            state_d = S_OUT;
          end
        end else if (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          etmo_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_OUT: begin
        ovf_inc = tick;
        if (valid_q && m_ready) begin
          if (chan_q == 3'd7) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            scnt_d  = scnt_q + 16'd1;
            state_d = S_CHECK;
          end else begin
            chan_d = nxt_ch;
            data_d = buf_q[{nxt_ch, 4'b0000} +: 16];
            last_d = (nxt_ch == 3'd7);
          end
        end
      end
      S_CHECK: begin
        if (stop_any || ((burst_q != '0) && (scnt_q == burst_q))) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ovf_inc && (ocnt_q != '1)) begin
      ocnt_d = ocnt_q + 16'd1;
    end

    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
    end else if (stop && (state_q != S_IDLE)) begin
      stop_pend_d = 1'b1;
    end

    // Timeout is measured from the cycle the trigger first goes high.
    if ((state_d == S_TRIG) && (state_q != S_TRIG)) begin
      to_cnt_d = '0;
    end else if ((state_q == S_TRIG) || (state_q == S_WAIT_DONE)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    trig_d = (state_d == S_TRIG);
    run_d  = (state_d != S_IDLE);
    done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      burst_q     <= '0;
      per_q       <= '0;
      trig_cnt_q  <= '0;
      to_cnt_q    <= '0;
      buf_q       <= '0;
      stop_pend_q <= 1'b0;
      samp_q      <= 1'b0;
      fall_q      <= 1'b0;
      err_s_q     <= 1'b0;
      trig_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      chan_q      <= '0;
      last_q      <= 1'b0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      scnt_q      <= '0;
      ocnt_q      <= '0;
      etmo_q      <= 1'b0;
      eadc_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      burst_q     <= burst_d;
      per_q       <= per_d;
      trig_cnt_q  <= trig_cnt_d;
      to_cnt_q    <= to_cnt_d;
      buf_q       <= buf_d;
      stop_pend_q <= stop_pend_d;
      samp_q      <= adc_sampling;
      fall_q      <= samp_q & ~adc_sampling;
      err_s_q     <= adc_error;
      trig_q      <= trig_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      last_q      <= last_d;
      run_q       <= run_d;
      done_q      <= done_d;
      scnt_q      <= scnt_d;
      ocnt_q      <= ocnt_d;
      etmo_q      <= etmo_d;
      eadc_q      <= eadc_d;
    end
  end

  assign adc_trigger = trig_q;
  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign m_channel   = chan_q;
  assign m_last      = last_q;
  assign run         = run_q;
  assign done        = done_q;
  assign sample_cnt  = scnt_q;
  assign overrun_cnt = ocnt_q;
  assign err_timeout = etmo_q;
  assign err_adc     = eadc_q;

endmodule

// File: tb/tb_vuprs_adc_sample_sched.sv
// Bench for vuprs_adc_sample_sched: controller model, stream scoreboard and a
// slot-level schedule model derived from the trigger period rules.
module tb_vuprs_adc_sample_sched;

  localparam int TH = 4;
  localparam int TO = 2000;
  localparam int MD = 63;

  logic         clk, rst, start, stop;
  logic [23:0]  cfg_divider;
  logic [15:0]  cfg_burst;
  logic         adc_trigger, adc_sampling, adc_error, adc_reset_down;
  logic [127:0] adc_ch_data;
  logic         m_valid, m_ready;
  logic [15:0]  m_data;
  logic [2:0]   m_channel;
  logic         m_last, run, done;
  logic [15:0]  sample_cnt, overrun_cnt;
  logic         err_timeout, err_adc;

  vuprs_adc_sample_sched #(
    .TRIG_HIGH(TH),
    .TIMEOUT_CYCLES(TO),
    .MIN_DIV(MD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_divider(cfg_divider), .cfg_burst(cfg_burst),
    .adc_trigger(adc_trigger), .adc_sampling(adc_sampling),
    .adc_error(adc_error), .adc_reset_down(adc_reset_down),
    .adc_ch_data(adc_ch_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_channel(m_channel), .m_last(m_last),
    .run(run), .done(done), .sample_cnt(sample_cnt), .overrun_cnt(overrun_cnt),
    .err_timeout(err_timeout), .err_adc(err_adc)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int words = 0;
  int trig_t[$];
  int chk_c[$];
  logic [127:0] exp_q[$];

  int ctl_conv = 20;
  bit ctl_hang = 0;
  bit ctl_error = 0;
  bit rnd_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model: busy one cycle after the trigger, new data on completion.
  initial begin
    logic [127:0] smp;
    adc_sampling = 1'b0;
    adc_error    = 1'b0;
    adc_ch_data  = '0;
    forever begin
      @(posedge adc_trigger);
      if (!ctl_hang) begin
        @(posedge clk); #1;
        adc_sampling = 1'b1;
        adc_error    = 1'b0;
        repeat (ctl_conv) @(posedge clk);
        #1;
        smp = {$urandom, $urandom, $urandom, $urandom};
        adc_ch_data  = smp;
        adc_error    = ctl_error;
        adc_sampling = 1'b0;
        if (!ctl_error) exp_q.push_back(smp);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  // Trigger monitor: slot (tick) cycle is the one before the rising edge.
  bit trig_prev = 0;
  int hi_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      trig_prev = 0;
      hi_cnt = 0;
    end else begin
      if (adc_trigger && !trig_prev) trig_t.push_back(cyc - 1);
      if (adc_trigger) hi_cnt++;
      else if (trig_prev) begin
        chk("trig_width", hi_cnt, TH);
        hi_cnt = 0;
      end
      trig_prev = adc_trigger;
    end
  end

  // Stream scoreboard and stall stability.
  int widx = 0;
  bit stalled = 0;
  logic [15:0] st_data;
  logic [2:0] st_ch;
  always @(negedge clk) begin
    logic [127:0] cur;
    if (!rst) begin
      widx = 0;
      stalled = 0;
    end else begin
      if (stalled && m_valid) begin
        chk("stall_data", m_data, st_data);
        chk("stall_chan", m_channel, st_ch);
      end
      if (m_valid && m_ready) begin
        words++;
        stalled = 0;
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          chk("m_data", m_data, cur[widx*16 +: 16]);
          chk("m_channel", m_channel, widx);
          chk("m_last", m_last, widx == 7);
          if (widx == 7) begin
            void'(exp_q.pop_front());
            chk_c.push_back(cyc + 1);
            widx = 0;
          end else widx++;
        end
      end else if (m_valid) begin
        stalled = 1;
        st_data = m_data;
        st_ch = m_channel;
      end else stalled = 0;
    end
  end

  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      chk("done_with_run_low", run, 0);
    end
  end

  // Slot model: ticks every per cycles from the first trigger slot; a sample
  // triggers on the first tick after its predecessor's CHECK cycle, every other
  // tick up to the final CHECK is lost, except one landing on a CHECK cycle.
  task automatic check_sched(input string name, input int per, input int n_exp);
    int t0, lost, k;
    bit used;
    chk({name, "_ntrig"}, trig_t.size(), n_exp);
    chk({name, "_nsamp"}, chk_c.size(), n_exp);
    if (trig_t.size() == n_exp && chk_c.size() == n_exp && n_exp > 0) begin
      t0 = trig_t[0];
      lost = 0;
      for (int i = 1; i < n_exp; i++) begin
        k = (chk_c[i-1] + 1 - t0 + per - 1) / per;
        chk({name, "_slot"}, trig_t[i], t0 + k * per);
      end
      for (int t = t0 + per; t <= chk_c[n_exp-1]; t += per) begin
        used = 0;
        foreach (trig_t[j]) if (trig_t[j] == t) used = 1;
        foreach (chk_c[j]) if (chk_c[j] == t) used = 1;
        if (!used) lost++;
      end
      chk({name, "_overrun"}, overrun_cnt, lost);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return m_valid && (m_channel == 3'd2);
      1: return adc_trigger;
      2: return err_timeout;
      3: return err_adc;
      4: return sample_cnt == 16'd10;
      default: return m_valid;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int budget, input string name);
    int n = 0;
    while (!cond(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait"}, cond(which), 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    chk({name, "_run_low"}, run, 0);
  endtask

  task automatic begin_run(input logic [23:0] d, input logic [15:0] b);
    @(posedge clk); #1;
    trig_t.delete();
    chk_c.delete();
    cfg_divider = d;
    cfg_burst = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_trigger"}, adc_trigger, 0);
    chk({name, "_m_valid"}, m_valid, 0);
    chk({name, "_m_data"}, m_data, 0);
    chk({name, "_m_channel"}, m_channel, 0);
    chk({name, "_m_last"}, m_last, 0);
    chk({name, "_run"}, run, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_sample_cnt"}, sample_cnt, 0);
    chk({name, "_overrun_cnt"}, overrun_cnt, 0);
    chk({name, "_err_timeout"}, err_timeout, 0);
    chk({name, "_err_adc"}, err_adc, 0);
  endtask

  typedef struct {
    logic [23:0] div;
    logic [15:0] burst;
    int          period;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int w0, rd_cyc, to_cyc, d0, d, b;

    tbl[0] = '{24'd10,  16'd3, 64};
    tbl[1] = '{24'd62,  16'd2, 64};
    tbl[2] = '{24'd63,  16'd2, 64};
    tbl[3] = '{24'd64,  16'd2, 65};
    tbl[4] = '{24'd150, 16'd3, 151};

    rst = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_divider = '0; cfg_burst = '0;
    adc_reset_down = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;

    // start+stop together, and stop alone, in IDLE do nothing
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 stop = 1'b0;
    repeat (5) @(negedge clk);
    chk("start_stop_run", run, 0);
    chk("start_stop_done", done_cnt - d0, 0);

    // Clamp and burst table
    for (int i = 0; i < 5; i++) begin
      w0 = words;
      begin_run(tbl[i].div, tbl[i].burst);
      if (i == 0) begin
        repeat (20) @(negedge clk);
        chk("wait_rdy_run", run, 1);
        chk("wait_rdy_no_trig", trig_t.size(), 0);
        @(posedge clk); #1;
        adc_reset_down = 1'b1;
        rd_cyc = cyc;
      end
      wait_done(2000, "tbl");
      if (i == 0 && trig_t.size() > 0) begin
        chk("first_trig_delay", (trig_t[0] - rd_cyc >= 64) && (trig_t[0] - rd_cyc <= 65), 1);
      end
      chk("tbl_sample_cnt", sample_cnt, tbl[i].burst);
      chk("tbl_words", words - w0, 8 * tbl[i].burst);
      chk("tbl_exp_empty", exp_q.size(), 0);
      check_sched("tbl", tbl[i].period, tbl[i].burst);
      for (int j = 1; j < trig_t.size(); j++)
        chk("tbl_period", trig_t[j] - trig_t[j-1], tbl[i].period);
    end

    // Continuous run, 10 samples, no stalls
    ctl_conv = 200;
    begin_run(24'd2499, 16'd0);
    wait_cond(4, 30000, "cont_ten");
    pulse_stop();
    wait_done(100, "cont");
    chk("cont_sample_cnt", sample_cnt, 10);
    check_sched("cont", 2500, 10);

    // Back-pressure for 5000 cycles during OUT
    w0 = words;
    begin_run(24'd2499, 16'd2);
    wait_cond(0, 5000, "bp_ch2");
    @(posedge clk); #1 m_ready = 1'b0;
    repeat (5000) @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done(10000, "bp");
    chk("bp_overrun", overrun_cnt, 2);
    chk("bp_sample_cnt", sample_cnt, 2);
    chk("bp_words", words - w0, 16);
    check_sched("bp", 2500, 2);

    // Timeout: controller never goes busy
    ctl_hang = 1;
    w0 = words;
    begin_run(24'd2499, 16'd1);
    wait_cond(1, 3000, "to_trig");
    wait_cond(2, 2500, "to_flag");
    to_cyc = cyc;
    ctl_hang = 0;
    if (trig_t.size() > 0) chk("to_delay", to_cyc - (trig_t[0] + 1), TO);
    wait_done(5000, "to");
    chk("to_ntrig", trig_t.size(), 2);
    if (trig_t.size() == 2) chk("to_next_trig", trig_t[1] - trig_t[0], 2500);
    chk("to_sticky", err_timeout, 1);
    chk("to_sample_cnt", sample_cnt, 1);
    chk("to_overrun", overrun_cnt, 0);
    chk("to_words", words - w0, 8);

    // ADC error at completion; divider 0 clamps to the minimum
    ctl_conv = 20;
    ctl_error = 1;
    w0 = words;
    begin_run(24'd0, 16'd1);
    chk("start_clears_to", err_timeout, 0);
    wait_cond(3, 500, "adc_err");
    ctl_error = 0;
    chk("adc_err_words", words - w0, 0);
    chk("adc_err_sample_cnt", sample_cnt, 0);
    wait_done(1000, "adc_err");
    chk("adc_err_sticky", err_adc, 1);
    chk("adc_err_final_cnt", sample_cnt, 1);
    chk("adc_err_final_words", words - w0, 8);
    chk("adc_err_exp_empty", exp_q.size(), 0);

    // Stop during OUT: remaining words of that sample still stream
    w0 = words;
    begin_run(24'd100, 16'd0);
    chk("start_clears_adc", err_adc, 0);
    wait_cond(0, 500, "stop_ch2");
    pulse_stop();
    wait_done(200, "stop");
    chk("stop_words", words - w0, 8);
    chk("stop_sample_cnt", sample_cnt, 1);
    check_sched("stop", 101, 1);

    // Randomized runs against the slot model and scoreboard
    for (int r = 0; r < 4; r++) begin
      d = MD + $urandom_range(0, 40);
      b = $urandom_range(1, 4);
      ctl_conv = $urandom_range(5, 90);
      w0 = words;
      rnd_ready = 1;
      begin_run(24'(d), 16'(b));
      chk("rnd_err_adc_clr", err_adc, 0);
      chk("rnd_ovr_clr", overrun_cnt, 0);
      wait_done(6000, "rnd");
      rnd_ready = 0;
      #2 m_ready = 1'b1;
      chk("rnd_sample_cnt", sample_cnt, b);
      chk("rnd_words", words - w0, 8 * b);
      chk("rnd_exp_empty", exp_q.size(), 0);
      check_sched("rnd", d + 1, b);
    end

    // Asynchronous reset during TRIG, then during OUT
    ctl_conv = 20;
    begin_run(24'd2499, 16'd0);
    wait_cond(1, 3000, "rst_trig");
    rst = 1'b0;
    #1;
    chk("rst_trig_async", adc_trigger, 0);
    chk("rst_run_async", run, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_trig");
    @(posedge clk); #1 rst = 1'b1;
    repeat (300) @(negedge clk);
    exp_q.delete();
    begin_run(24'd63, 16'd0);
    wait_cond(5, 500, "rst_out");
    rst = 1'b0;
    #1;
    chk("rst_valid_async", m_valid, 0);
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_out");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
